ext_arbiter: RTL
================

# ext_arbiter

Round-robin arbiter that shares the single immediate extender between two requesters, e.g. the decode-stage ALU-immediate path and the branch-offset path. Each requester gets a valid/ready request channel and a private one-entry registered response channel. The arbiter drives the shared extender's `imm`/`EOp` inputs, captures its combinational 32-bit result and returns it to the winning requester one cycle later. It also keeps saturating grant and conflict counters for performance debug.

## Interface

- `CNT_W`, 16: width of each statistics counter.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `in_valid0`, `in_valid1`  in  1  request valid for requester 0 / 1.
- `in_ready0`, `in_ready1`  out  1  request accepted this cycle (grant).
- `in_imm0`, `in_imm1`  in  16  immediate to extend.
- `in_op0`, `in_op1`  in  2  extension op (00 sign, 01 zero, 10 upper-half, 11 sign then <<2).
- `out_valid0`, `out_valid1`  out  1  response register holds data.
- `out_ready0`, `out_ready1`  in  1  requester consumes response.
- `out_data0`, `out_data1`  out  32  extended result.
- `ext_imm`  out  16  to shared extender `imm`.
- `ext_op`  out  2  to shared extender `EOp`.
- `ext_data`  in  32  combinational result from shared extender.
- `grant_cnt0`, `grant_cnt1`  out  CNT_W  grants per requester, saturating.
- `conflict_cnt`  out  CNT_W  cycles where both requesters were eligible, saturating.

## Operation

- Eligibility: `elig_i = in_valid_i && (!out_valid_i || out_ready_i)`. A requester is never granted while its response register is full and not being drained.
- Priority pointer `prio` (1 bit, reset 0):
  - Both eligible: grant requester `prio`, and count the cycle as a conflict.
  - One eligible: grant it.
  - None eligible: no grant.
  - After any grant to i, `prio <= ~i`. Without a grant, `prio` holds.
- `in_ready_i` is combinational and equals `grant_i`. At most one grant per cycle. Ready may depend on valid; valid must never depend on ready.
- Shared extender drive: `ext_imm`/`ext_op` are the granted requester's `in_imm`/`in_op`. They are 16'h0/2'b00 when there is no grant.
- Response register i:
  - On `grant_i`: `out_data_i <= ext_data`, `out_valid_i <= 1`.
  - Else on `out_valid_i && out_ready_i`: `out_valid_i <= 0`, and `out_data_i` holds its last value.
  - Drain and new grant in the same cycle: `out_valid_i` stays 1 and the data is replaced.
- `out_data_i` is stable whenever `out_valid_i && !out_ready_i`.
- Counters: `grant_cnt_i` +1 per `grant_i`; `conflict_cnt` +1 per conflict cycle. All saturate at all-ones and never wrap.
- The arbiter does not interpret `in_op`. Result correctness comes from the extender.

## Timing

- Reset values, while `reset`=0: all `out_valid` 0, `out_data` 32'h0, `prio` 0, all counters 0.
- During reset, `in_ready` outputs are forced 0 and `ext_imm`/`ext_op` are 0.
- Reset asserted mid-transaction clears everything asynchronously, without waiting for a clock edge. A request presented in that cycle is lost. The requester must re-present it after reset is released.
- Latency: request accepted at edge N gives `out_valid_i`=1 with data after edge N. Throughput is one response per requester per cycle when `out_ready_i` is held 1. The aggregate is one grant per cycle.
- Fairness: with both requesters continuously eligible, grants alternate 0,1,0,1… starting with requester 0 after reset.
- A requester blocked by its own full response register does not block the other. The other may be granted every cycle, with no grant lost.

## Test plan

- Single request: `in_valid0`=1, `in_imm0`=16'h8001, `in_op0`=00, `out_ready0`=1. Required: `in_ready0`=1 the same cycle, `ext_imm`=16'h8001; next cycle `out_valid0`=1, `out_data0`=32'hFFFF8001, `grant_cnt0`=1.
- Conflict: both valid from reset, req0 16'h1234/op 10, req1 16'hFFFF/op 01, both `out_ready`=1. Required: cycle 0 grants 0, giving `out_data0`=32'h12340000; cycle 1 grants 1, giving `out_data1`=32'h0000FFFF; `conflict_cnt`≥1; grants alternate thereafter.
- Op 11: req1 16'hFFFE/op 11. Required: `out_data1`=32'hFFFFFFF8 one cycle after grant.
- Backpressure: `out_ready0`=0 with response 0 full and a second req0 pending. Required: `in_ready0`=0 and `out_data0` stable for 5 cycles while req1 is granted every cycle. Then raise `out_ready0`: drain and new grant in the same cycle, and `out_valid0` stays 1.
- Saturation: `CNT_W`=4, 20 back-to-back req0 grants. Required: `grant_cnt0`=4'hF and it stays there.
- Async reset: drop `reset` between edges while `out_valid1`=1. Required: `out_valid1`=0, counters 0 and `prio`=0 immediately. After release, the first conflict grants requester 0.

Source files
------------

// File: rtl/ext_arbiter.sv
// ext_arbiter: round-robin arbiter sharing one combinational immediate
// extender between two requesters.
//
// Ports:
//   clk                     rising-edge clock
//   reset                   asynchronous, active-low reset
//   in_valid0/1, in_ready0/1  request handshake; ready is the grant
//   in_imm0/1, in_op0/1       immediate and extension op per requester
//   out_valid0/1, out_ready0/1, out_data0/1
//                           one-entry registered response per requester
//   ext_imm, ext_op         drive the shared extender (zero when no grant)
//   ext_data                combinational result from the shared extender
//   grant_cnt0/1            saturating grant counters
//   conflict_cnt            saturating count of cycles with both eligible
module ext_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid0,
  input  logic             in_valid1,
  output logic             in_ready0,
  output logic             in_ready1,
  input  logic [15:0]      in_imm0,
  input  logic [15:0]      in_imm1,
  input  logic [1:0]       in_op0,
  input  logic [1:0]       in_op1,
  output logic             out_valid0,
  output logic             out_valid1,
  input  logic             out_ready0,
  input  logic             out_ready1,
  output logic [31:0]      out_data0,
  output logic [31:0]      out_data1,
  output logic [15:0]      ext_imm,
  output logic [1:0]       ext_op,
  input  logic [31:0]      ext_data,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic {
    PRIO_REQ0 = 1'b0,
    PRIO_REQ1 = 1'b1
  } prio_e;

  prio_e            prio_q, prio_d;
  logic             out_valid0_q, out_valid0_d;
  logic             out_valid1_q, out_valid1_d;
  logic [31:0]      out_data0_q, out_data0_d;
  logic [31:0]      out_data1_q, out_data1_d;
  logic [CNT_W-1:0] grant_cnt0_q, grant_cnt0_d;
  logic [CNT_W-1:0] grant_cnt1_q, grant_cnt1_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  logic elig0, elig1;
  logic grant0, grant1;
  logic conflict;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    elig0    = in_valid0 && (!out_valid0_q || out_ready0);
    elig1    = in_valid1 && (!out_valid1_q || out_ready1);
    // reset gating keeps grants low while the async reset is held
    grant0   = reset && elig0 && (!elig1 || (prio_q == PRIO_REQ0));
    grant1   = reset && elig1 && (!elig0 || (prio_q == PRIO_REQ1));
    conflict = reset && elig0 && elig1;
  end

  always_comb begin
    prio_d         = prio_q;
    out_valid0_d   = out_valid0_q;
    out_valid1_d   = out_valid1_q;
    out_data0_d    = out_data0_q;
    out_data1_d    = out_data1_q;
    ext_imm        = '0;
    ext_op         = '0;

    if (grant0) begin
      prio_d  = PRIO_REQ1;
      ext_imm = in_imm0;
      ext_op  = in_op0;
    end else if (grant1) begin
      prio_d  = PRIO_REQ0;
      ext_imm = in_imm1;
      ext_op  = in_op1;
    end

    if (grant0) begin
      out_valid0_d = 1'b1;
      out_data0_d  = ext_data;
    end else if (out_valid0_q && out_ready0) begin
      out_valid0_d = 1'b0;
    end

    if (grant1) begin
      out_valid1_d = 1'b1;
      out_data1_d  = ext_data;
    end else if (out_valid1_q && out_ready1) begin
      out_valid1_d = 1'b0;
    end

    grant_cnt0_d   = sat_inc(grant_cnt0_q, grant0);
    grant_cnt1_d   = sat_inc(grant_cnt1_q, grant1);
    conflict_cnt_d = sat_inc(conflict_cnt_q, conflict);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q         <= PRIO_REQ0;
      out_valid0_q   <= 1'b0;
      out_valid1_q   <= 1'b0;
      out_data0_q    <= '0;
      out_data1_q    <= '0;
      grant_cnt0_q   <= '0;
      grant_cnt1_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      prio_q         <= prio_d;
      out_valid0_q   <= out_valid0_d;
      out_valid1_q   <= out_valid1_d;
      out_data0_q    <= out_data0_d;
      out_data1_q    <= out_data1_d;
      grant_cnt0_q   <= grant_cnt0_d;
      grant_cnt1_q   <= grant_cnt1_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign in_ready0    = grant0;
  assign in_ready1    = grant1;
  assign out_valid0   = out_valid0_q;
  assign out_valid1   = out_valid1_q;
  assign out_data0    = out_data0_q;
  assign out_data1    = out_data1_q;
  assign grant_cnt0   = grant_cnt0_q;
  assign grant_cnt1   = grant_cnt1_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule
